// File: rtl/uart_mmio_ctrl.sv
// Bus-side UART controller: TX byte FIFO paced one frame at a time into the UART,
// RX byte capture with flag handshake, and a status register with sticky error bits.
module uart_mmio_ctrl #(
    parameter int Nbit       = 8,
    parameter int baudrate   = 9600,
    parameter int clk_freq   = 50000000,
    parameter int FRAME_BITS = 11,
    parameter int TX_DEPTH   = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [3:0]      Addr,
    input  logic            WE,
    input  logic            RE,
    input  logic [31:0]     WriteData,
    output logic [31:0]     ReadData,
    input  logic [Nbit-1:0] DataRx,
    input  logic            Rx_flag,
    input  logic            Parity_error,
    output logic            clr_rx_flag,
    output logic            Transmit,
    output logic [Nbit-1:0] DataTx
);

    localparam int BIT_CYCLES   = clk_freq / baudrate;
    localparam int FRAME_CYCLES = FRAME_BITS * BIT_CYCLES;
    localparam int PTR_W        = $clog2(TX_DEPTH);
    localparam int CNT_W        = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);
    localparam logic [PTR_W:0]   FIFO_FULL  = (PTR_W + 1)'(TX_DEPTH);

    localparam logic [1:0] REG_TXDATA = 2'b00;
    localparam logic [1:0] REG_RXDATA = 2'b01;
    localparam logic [1:0] REG_STATUS = 2'b10;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    logic [Nbit-1:0]  fifo_mem [TX_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             tx_full;
    logic             tx_empty;
    logic             tx_busy;
    logic             tx_overflow;
    logic             push_req;
    logic             push;
    logic             pop;

    logic [0:0]       state;
    logic [CNT_W-1:0] cnt;

    logic [Nbit-1:0]  rx_buf;
    logic             rx_valid;
    logic             rx_perr;
    logic             rx_overrun;
    logic             rd_rx;
    logic             status_wr;
    logic             capture;

    // Only some WriteData bits and no Addr[1:0] bits carry meaning.
    logic unused_bus_bits;
    assign unused_bus_bits = ^{WriteData, Addr[1:0]};

    assign tx_full   = (count == FIFO_FULL);
    assign tx_empty  = (count == '0);
    assign tx_busy   = (state == S_WAIT);
    assign push_req  = WE && (Addr[3:2] == REG_TXDATA);
    assign pop       = (state == S_IDLE) && !tx_empty;
    // A full FIFO still accepts a write in the cycle its head is popped.
    assign push      = push_req && (!tx_full || pop);
    assign rd_rx     = RE && (Addr[3:2] == REG_RXDATA);
    assign status_wr = WE && (Addr[3:2] == REG_STATUS);
    assign capture   = Rx_flag && !clr_rx_flag;

    // NOTE: storage arrays carry no reset; emptiness is tracked by pointers and count alone.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= WriteData[Nbit-1:0];
        end
    end

    // NOTE: all clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            tx_overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            tx_overflow <= (push_req && !push) ||
                           (tx_overflow && !(status_wr && WriteData[6]));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            Transmit <= 1'b0;
            DataTx   <= '0;
        end else begin
            Transmit <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!tx_empty) begin
                        Transmit <= 1'b1;
                        DataTx   <= fifo_mem[rd_ptr];
                        cnt      <= FRAME_LAST;
                        state    <= S_WAIT;
                    end
                end
                default: begin
                    if (cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    // Rx_flag is ignored while our own clear pulse is still in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_buf      <= '0;
            rx_valid    <= 1'b0;
            rx_perr     <= 1'b0;
            rx_overrun  <= 1'b0;
            clr_rx_flag <= 1'b0;
        end else begin
            clr_rx_flag <= capture;
            if (capture) begin
                rx_buf   <= DataRx;
                rx_perr  <= Parity_error;
                rx_valid <= 1'b1;
            end else if (rd_rx) begin
                rx_valid <= 1'b0;
            end
            rx_overrun <= (capture && rx_valid && !rd_rx) ||
                          (rx_overrun && !(status_wr && WriteData[2]));
        end
    end

    // NOTE: ReadData gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        ReadData = '0;
        case (Addr[3:2])
            REG_RXDATA: ReadData[Nbit-1:0] = rx_buf;
            REG_STATUS: ReadData[6:0] = {tx_overflow, tx_busy, tx_empty, tx_full,
                                         rx_overrun, rx_perr, rx_valid};
            default:    ReadData = '0;
        endcase
    end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Self-checking bench for uart_mmio_ctrl: a queue-based behavioural model checked every
// cycle, plus directed scenarios pinned with hand-computed literal expectations.
module tb_uart_mmio_ctrl;

    localparam int NBIT         = 8;
    localparam int CLK_FREQ     = 1000;
    localparam int BAUD         = 100;
    localparam int FB           = 11;
    localparam int DEPTH        = 4;
    localparam int FRAME_CYCLES = FB * (CLK_FREQ / BAUD);

    localparam logic [3:0] A_TX   = 4'h0;
    localparam logic [3:0] A_RX   = 4'h4;
    localparam logic [3:0] A_ST   = 4'h8;
    localparam logic [3:0] A_RSVD = 4'hC;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      Addr;
    logic            WE;
    logic            RE;
    logic [31:0]     WriteData;
    logic [31:0]     ReadData;
    logic [NBIT-1:0] DataRx;
    logic            Rx_flag;
    logic            Parity_error;
    logic            clr_rx_flag;
    logic            Transmit;
    logic [NBIT-1:0] DataTx;

    uart_mmio_ctrl #(
        .Nbit(NBIT), .baudrate(BAUD), .clk_freq(CLK_FREQ), .FRAME_BITS(FB), .TX_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .RE(RE), .WriteData(WriteData),
        .ReadData(ReadData), .DataRx(DataRx), .Rx_flag(Rx_flag), .Parity_error(Parity_error),
        .clr_rx_flag(clr_rx_flag), .Transmit(Transmit), .DataTx(DataTx)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: queue of pending bytes and a cycles-until-line-free counter.
    byte unsigned    mq[$];
    int              busy_left;
    bit              m_transmit, m_clr, m_valid, m_perr, m_overrun, m_overflow;
    logic [NBIT-1:0] m_datatx, m_rxbuf;
    bit              m_pop, m_push_req, m_rd_rx, m_st_wr, m_capture;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mq.delete();
            busy_left  = 0;
            m_transmit = 0;
            m_clr      = 0;
            m_valid    = 0;
            m_perr     = 0;
            m_overrun  = 0;
            m_overflow = 0;
            m_datatx   = '0;
            m_rxbuf    = '0;
        end else begin
            m_push_req = WE && (Addr[3:2] == 2'b00);
            m_rd_rx    = RE && (Addr[3:2] == 2'b01);
            m_st_wr    = WE && (Addr[3:2] == 2'b10);
            m_capture  = Rx_flag && !m_clr;
            m_pop      = (busy_left == 0) && (mq.size() > 0);

            if (busy_left > 0) busy_left--;
            m_transmit = m_pop;
            if (m_pop) begin
                m_datatx  = mq.pop_front();
                busy_left = FRAME_CYCLES;
            end
            if (m_st_wr && WriteData[6]) m_overflow = 0;
            if (m_push_req) begin
                if (mq.size() < DEPTH) mq.push_back(WriteData[7:0]);
                else m_overflow = 1;
            end

            if (m_st_wr && WriteData[2]) m_overrun = 0;
            if (m_capture) begin
                if (m_valid && !m_rd_rx) m_overrun = 1;
                m_rxbuf = DataRx;
                m_perr  = Parity_error;
                m_valid = 1;
            end else if (m_rd_rx) begin
                m_valid = 0;
            end
            m_clr = m_capture;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [3:0] a);
        case (a[3:2])
            2'b01:   return {24'b0, m_rxbuf};
            2'b10:   return {25'b0, m_overflow, (busy_left > 0), (mq.size() == 0),
                             (mq.size() == DEPTH), m_overrun, m_perr, m_valid};
            default: return 32'h0;
        endcase
    endfunction

    always @(negedge clk) begin
        check("Transmit", {31'b0, Transmit}, {31'b0, m_transmit});
        check("DataTx", {24'b0, DataTx}, {24'b0, m_datatx});
        check("clr_rx_flag", {31'b0, clr_rx_flag}, {31'b0, m_clr});
        check("ReadData", ReadData, exp_rd(Addr));
    end

    int cyc = 0;
    int tx_times[$];
    byte unsigned tx_bytes[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (Transmit === 1'b1) begin
            tx_times.push_back(cyc);
            tx_bytes.push_back(DataTx);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
        Addr = a;
        WriteData = d;
        WE = 1'b1;
        tick();
        WE = 1'b0;
    endtask

    task automatic peek(input logic [3:0] a, input logic [31:0] exp, input string name);
        Addr = a;
        #1;
        check(name, ReadData, exp);
    endtask

    task automatic wait_pulses(input int n, input int budget);
        for (int i = 0; i < budget && tx_times.size() < n; i++) tick();
        check("tx pulse count", tx_times.size(), n);
    endtask

    task automatic rx_byte(input logic [7:0] d);
        DataRx = d;
        Parity_error = 1'b0;
        Rx_flag = 1'b1;
        tick();
        Rx_flag = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        Addr = A_TX;
        WE = 1'b0;
        RE = 1'b0;
        WriteData = '0;
        DataRx = '0;
        Rx_flag = 1'b0;
        Parity_error = 1'b0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        peek(A_ST, 32'h10, "status after reset");
        check("Transmit after reset", {31'b0, Transmit}, 32'h0);
        check("clr after reset", {31'b0, clr_rx_flag}, 32'h0);
        peek(A_RX, 32'h0, "rxdata after reset");
        bus_write(A_RSVD, 32'hFFFF_FFFF);
        peek(A_RSVD, 32'h0, "reserved read");
        peek(A_ST, 32'h10, "status after reserved write");

        // Three bytes, paced one frame apart
        tx_times.delete();
        tx_bytes.delete();
        bus_write(A_TX, 32'h41);
        bus_write(A_TX, 32'h42);
        bus_write(A_TX, 32'h43);
        Addr = A_ST;
        wait_pulses(3, 500);
        peek(A_ST, 32'h30, "status after third pop");
        for (int i = 0; i < tx_bytes.size(); i++) check("tx byte", tx_bytes[i], 32'h41 + i);
        for (int i = 1; i < tx_times.size(); i++)
            check("tx spacing", tx_times[i] - tx_times[i-1], 111);
        repeat (120) tick();
        peek(A_ST, 32'h10, "status idle after frames");

        // Overflow: 6 writes, 5 accepted
        tx_times.delete();
        tx_bytes.delete();
        for (int i = 1; i <= 6; i++) bus_write(A_TX, i);
        peek(A_ST, 32'h68, "status overflow full busy");
        bus_write(A_ST, 32'h40);
        peek(A_ST, 32'h28, "overflow cleared");
        wait_pulses(5, 5 * 111 + 50);
        for (int i = 0; i < tx_bytes.size(); i++) check("overflow tx byte", tx_bytes[i], i + 1);
        repeat (150) tick();
        check("sixth byte dropped", tx_times.size(), 5);
        peek(A_ST, 32'h10, "status drained");

        // RX capture with parity error
        Addr = A_ST;
        DataRx = 8'h5A;
        Parity_error = 1'b1;
        Rx_flag = 1'b1;
        tick();
        check("clr pulse high", {31'b0, clr_rx_flag}, 32'h1);
        peek(A_ST, 32'h13, "status after capture");
        tick();
        Rx_flag = 1'b0;
        Parity_error = 1'b0;
        check("clr pulse low", {31'b0, clr_rx_flag}, 32'h0);
        peek(A_ST, 32'h13, "flag ignored in clr cycle");
        Addr = A_RX;
        RE = 1'b1;
        #1;
        check("rxdata read", ReadData, 32'h5A);
        tick();
        RE = 1'b0;
        Addr = A_ST;
        #1;
        check("rx_valid cleared", {31'b0, ReadData[0]}, 32'h0);

        // Overrun, clear, simultaneous read, set-wins
        rx_byte(8'h11);
        rx_byte(8'h22);
        peek(A_RX, 32'h22, "overwritten byte");
        peek(A_ST, 32'h15, "overrun set");
        bus_write(A_ST, 32'h04);
        peek(A_ST, 32'h11, "overrun cleared");
        DataRx = 8'h33;
        Rx_flag = 1'b1;
        Addr = A_RX;
        RE = 1'b1;
        tick();
        RE = 1'b0;
        Rx_flag = 1'b0;
        peek(A_ST, 32'h11, "read+capture no overrun");
        peek(A_RX, 32'h33, "read+capture byte");
        tick();
        DataRx = 8'h44;
        Rx_flag = 1'b1;
        Addr = A_ST;
        WriteData = 32'h04;
        WE = 1'b1;
        tick();
        WE = 1'b0;
        Rx_flag = 1'b0;
        peek(A_ST, 32'h15, "overrun set wins over clear");
        tick();
        bus_write(A_ST, 32'h04);
        Addr = A_RX;
        RE = 1'b1;
        tick();
        RE = 1'b0;
        peek(A_ST, 32'h10, "rx idle");

        // Reset mid-frame with two bytes queued
        bus_write(A_TX, 32'hA1);
        bus_write(A_TX, 32'hA2);
        bus_write(A_TX, 32'hA3);
        repeat (50) tick();
        peek(A_ST, 32'h20, "busy with two queued");
        tx_times.delete();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("Transmit after abort", {31'b0, Transmit}, 32'h0);
        peek(A_ST, 32'h10, "status after abort");
        repeat (200) tick();
        check("no tx after abort", tx_times.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_mmio_ctrl.md
# uart_mmio_ctrl

Memory-mapped controller between the MIPS data bus and the UART block. Owns the processor-side end of the UART parallel interface: it buffers bytes written by software in a small TX FIFO, paces them into the UART transmitter one frame at a time, and captures received bytes into a readable register. It also clears the UART receive flag and reports status and sticky error bits to software.

## Interface
- Nbit, 8: UART data width; also the TXDATA/RXDATA payload width.
- baudrate, 9600: line baud rate used for frame pacing.
- clk_freq, 50000000: system clock frequency in Hz.
- FRAME_BITS, 11: bit times per frame (start + Nbit + parity + stop).
- TX_DEPTH, 4: TX FIFO depth (power of 2, ≥2).
- Derived: BIT_CYCLES = clk_freq/baudrate (integer division); FRAME_CYCLES = FRAME_BITS*BIT_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Addr  in  4  byte address; Addr[3:2] selects the register.
- WE  in  1  bus write strobe, one cycle per access.
- RE  in  1  bus read strobe, one cycle per access.
- WriteData  in  32  bus write data.
- ReadData  out  32  bus read data, combinational from Addr.
- DataRx  in  Nbit  UART received byte.
- Rx_flag  in  1  UART byte-received flag (level, held until cleared).
- Parity_error  in  1  UART parity error for DataRx.
- clr_rx_flag  out  1  one-cycle pulse clearing Rx_flag.
- Transmit  out  1  one-cycle start pulse to the UART transmitter.
- DataTx  out  Nbit  byte to transmit; valid while Transmit is high and held afterwards.

## Operation
- Register map (Addr[3:2]):
  - 00 TXDATA: write pushes WriteData[Nbit-1:0]; reads return 0.
  - 01 RXDATA: reads return the buffered byte, zero-extended. RE clears rx_valid.
  - 10 STATUS: reads return bit0 rx_valid, bit1 rx_perr, bit2 rx_overrun, bit3 tx_full, bit4 tx_empty, bit5 tx_busy, bit6 tx_overflow, all other bits 0. Writes are write-1-to-clear on bit2 and bit6 only.
  - 11: reads return 0; writes are ignored.
- TX FIFO:
  - A write to TXDATA while full is dropped and sets tx_overflow.
  - A write coinciding with a pop while full is accepted.
  - Pointers wrap modulo TX_DEPTH. A count of TX_DEPTH+1 values gives the full and empty flags.
- TX FSM states:
  - IDLE: if the FIFO is non-empty, next edge registers Transmit=1 and DataTx=head, pops the FIFO, loads cnt=FRAME_CYCLES-1, and moves to WAIT.
  - WAIT: Transmit=0; cnt decrements each cycle; at cnt==0, next state is IDLE.
  - tx_busy = (state==WAIT).
- RX capture:
  - When Rx_flag=1 and clr_rx_flag=0 (the registered pulse from the previous cycle), the block:
    - latches DataRx into the RX buffer and Parity_error into rx_perr;
    - sets rx_valid;
    - pulses clr_rx_flag for one cycle.
  - Capture while rx_valid=1 and no RXDATA read in the same cycle: the new byte overwrites the buffer and rx_overrun is set.
  - Capture with a simultaneous RXDATA read: the new byte is latched, rx_valid stays 1, and rx_overrun is unchanged.
- Sticky bits: rx_overrun and tx_overflow remain set until cleared by a W1C write or reset. If a set and a clear occur in the same cycle, set wins.

## Timing
- Reset values:
  - Transmit=0, DataTx=0, clr_rx_flag=0.
  - FIFO empty; state IDLE; cnt=0.
  - RX buffer=0; all status bits 0 except tx_empty=1.
  - ReadData follows the reset register values.
  - Reset asserted mid-frame aborts the frame immediately; the FIFO contents are discarded.
- Write to empty FIFO in IDLE, sampled at edge E0: Transmit is high for exactly the cycle E1–E2.
- Back-to-back bytes: rising edges of Transmit are exactly FRAME_CYCLES+1 cycles apart.
- RX latency:
  - Rx_flag high at edge E0: rx_valid=1 and clr_rx_flag=1 after E0.
  - clr_rx_flag=0 after E1.
  - Rx_flag is ignored during the clr cycle.
- ReadData is combinational in the same cycle. RE/WE side effects take effect at the following edge.

## Test plan
- Use clk_freq=1000, baudrate=100, FRAME_BITS=11 (FRAME_CYCLES=110), TX_DEPTH=4.
- Reset → STATUS reads 0x10, Transmit=0, clr_rx_flag=0, ReadData at RXDATA = 0.
- Write 0x41, 0x42, 0x43 to TXDATA on consecutive cycles → Transmit pulses with DataTx 0x41/0x42/0x43; pulses are 111 cycles apart; tx_empty=1 after the third pop.
- Write 6 bytes back-to-back → the first 5 are accepted (one is popped immediately) and the 6th is dropped; tx_overflow=1. Writing STATUS with 0x40 → tx_overflow=0.
- Rx_flag=1 with DataRx=0x5A and Parity_error=1 → one clr_rx_flag pulse; STATUS bits 1:0 = 11; RXDATA read returns 0x5A; rx_valid=0 afterwards.
- Two captures (0x11, then 0x22) without a read → RXDATA=0x22 and rx_overrun=1. A capture simultaneous with a read → no overrun.
- Reset asserted 50 cycles into WAIT with 2 bytes queued → Transmit stays 0; STATUS=0x10 after release.
